// File: rtl/i2s_sample_frontend_pkg.sv
// Shared encodings for the I2S sample front end: handoff FSM states and channel select.
package i2s_sample_frontend_pkg;

   typedef enum logic [1:0] {
      FE_IDLE   = 2'd0,
      FE_ISSUED = 2'd1,
      FE_BUSY   = 2'd2
   } fe_state_t;

   localparam logic LEFT = 1'b0;

endpackage

// File: rtl/i2s_sample_frontend_rx_deser.sv
// I2S left-channel deserialiser: 2-FF input synchronisers, bclk rise detect,
// MSB-first shift register and bit counter, truncated word out with a done pulse.
module i2s_rx_deser
   import i2s_sample_frontend_pkg::*;
#(
   parameter int data_width   = 16,
   parameter int sample_width = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2s_bclk,
   input  logic                  i2s_lrclk,
   input  logic                  i2s_sdata,
   output logic [data_width-1:0] rx_word,
   output logic                  rx_done,
   output logic                  short_word
);

   localparam int IW = $clog2(sample_width + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(sample_width - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   logic bclk_s1, bclk_s2, bclk_d;
   logic lr_s1, lr_s2, lr_prev;
   logic sd_s1, sd_s2;
   logic collecting;
   logic [IW-1:0] bit_idx;
   logic [sample_width-2:0] shreg;
   logic [sample_width-1:0] shift_next;
   logic bclk_rise;

   assign bclk_rise  = bclk_s2 & ~bclk_d;
   assign shift_next = {shreg, sd_s2};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bclk_s1    <= 1'b0;
         bclk_s2    <= 1'b0;
         bclk_d     <= 1'b0;
         lr_s1      <= 1'b0;
         lr_s2      <= 1'b0;
         lr_prev    <= 1'b0;
         sd_s1      <= 1'b0;
         sd_s2      <= 1'b0;
         collecting <= 1'b0;
         bit_idx    <= '0;
         shreg      <= '0;
         rx_word    <= '0;
         rx_done    <= 1'b0;
         short_word <= 1'b0;
      end else begin
         bclk_s1    <= i2s_bclk;
         bclk_s2    <= bclk_s1;
         bclk_d     <= bclk_s2;
         lr_s1      <= i2s_lrclk;
         lr_s2      <= lr_s1;
         sd_s1      <= i2s_sdata;
         sd_s2      <= sd_s1;
         rx_done    <= 1'b0;
         short_word <= 1'b0;
         if (bclk_rise) begin
            lr_prev <= lr_s2;
            // The bit sampled on the word-select fall belongs to the previous word.
            if ((lr_prev != LEFT) && (lr_s2 == LEFT)) begin
               bit_idx    <= '0;
               collecting <= 1'b1;
            end else if (collecting) begin
               if (lr_s2 == LEFT) begin
                  shreg   <= shift_next[sample_width-2:0];
                  bit_idx <= bit_idx + IDX_ONE;
                  if (bit_idx == LAST_IDX) begin
                     rx_word    <= shift_next[sample_width-1 -: data_width];
                     rx_done    <= 1'b1;
                     collecting <= 1'b0;
                  end
               end else begin
                  short_word <= 1'b1;
                  collecting <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/i2s_sample_frontend.sv
// I2S front end for dsp_pipeline: one-deep sample slot with overrun counting,
// valid/ready-style handoff FSM and capture of the returned pipeline result.
module i2s_sample_frontend
   import i2s_sample_frontend_pkg::*;
#(
   parameter int data_width   = 16,
   parameter int sample_width = 24,
   parameter int count_width  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   i2s_bclk,
   input  logic                   i2s_lrclk,
   input  logic                   i2s_sdata,
   input  logic                   pipe_ready,
   input  logic [data_width-1:0]  pipe_out_sample,
   output logic [data_width-1:0]  in_sample,
   output logic                   in_valid,
   output logic [data_width-1:0]  out_latched,
   output logic                   out_valid,
   output logic [count_width-1:0] overrun_count,
   output logic                   frame_error,
   output fe_state_t              fe_state
);

   // Handshake: a sample is handed over by a one-cycle in_valid taken only in
   // IDLE with pipe_ready high; the pipeline then drops ready while it works and
   // raises it again with its result on pipe_out_sample, which is captured once.

   localparam logic [count_width-1:0] CNT_ONE = count_width'(1);

   logic [data_width-1:0] rx_word;
   logic                  rx_done;
   logic                  short_word;
   logic                  slot_full;
   logic [data_width-1:0] slot_data;
   logic                  load;
   logic                  issue;
   logic                  capture;
   fe_state_t             state, state_next;

   i2s_rx_deser #(
      .data_width  (data_width),
      .sample_width(sample_width)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .i2s_bclk  (i2s_bclk),
      .i2s_lrclk (i2s_lrclk),
      .i2s_sdata (i2s_sdata),
      .rx_word   (rx_word),
      .rx_done   (rx_done),
      .short_word(short_word)
   );

   assign load     = rx_done & enable;
   assign fe_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FE_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      capture    = 1'b0;
      case (state)
         FE_IDLE: begin
            if (slot_full && pipe_ready) begin
               issue      = 1'b1;
               state_next = FE_ISSUED;
            end
         end
         FE_ISSUED: begin
            if (!pipe_ready) state_next = FE_BUSY;
         end
         FE_BUSY: begin
            if (pipe_ready) begin
               capture    = 1'b1;
               state_next = FE_IDLE;
            end
         end
         default: state_next = FE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_full     <= 1'b0;
         slot_data     <= '0;
         in_sample     <= '0;
         in_valid      <= 1'b0;
         out_latched   <= '0;
         out_valid     <= 1'b0;
         overrun_count <= '0;
         frame_error   <= 1'b0;
      end else begin
         in_valid    <= issue;
         out_valid   <= capture;
         frame_error <= frame_error | short_word;
         if (issue)   in_sample   <= slot_data;
         if (capture) out_latched <= pipe_out_sample;
         // Latest word wins; an overrun is counted only when a full slot is not draining.
         if (load) begin
            slot_data <= rx_word;
            slot_full <= 1'b1;
            if (slot_full && !issue && (overrun_count != '1))
               overrun_count <= overrun_count + CNT_ONE;
         end else if (issue) begin
            slot_full <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_sample_frontend.sv
// Directed bench for i2s_sample_frontend: I2S word driver, pipeline model,
// handoff monitor and a second instance with a 4-bit counter for saturation.
module tb_i2s_sample_frontend;
   import i2s_sample_frontend_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        i2s_bclk = 1'b0;
   logic        i2s_lrclk = 1'b1;
   logic        i2s_sdata = 1'b0;
   logic        pipe_ready = 1'b0;
   logic [15:0] pipe_out_sample = '0;
   logic [15:0] in_sample;
   logic        in_valid;
   logic [15:0] out_latched;
   logic        out_valid;
   logic [15:0] overrun_count;
   logic        frame_error;
   fe_state_t   fe_state;

   logic        sat_ready = 1'b0;
   logic [15:0] sat_in_sample;
   logic        sat_in_valid;
   logic [15:0] sat_out_latched;
   logic        sat_out_valid;
   logic [3:0]  sat_count;
   logic        sat_frame_error;
   fe_state_t   sat_state;

   int checks = 0;
   int errors = 0;

   logic        model_on = 1'b0;
   logic [15:0] model_resp = '0;
   int          n_iv = 0;
   int          n_ov = 0;
   int          viol = 0;
   logic        busy = 1'b0;
   logic [15:0] in_log[$];

   i2s_sample_frontend #(.data_width(16), .sample_width(24), .count_width(16)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
      .pipe_ready(pipe_ready), .pipe_out_sample(pipe_out_sample),
      .in_sample(in_sample), .in_valid(in_valid),
      .out_latched(out_latched), .out_valid(out_valid),
      .overrun_count(overrun_count), .frame_error(frame_error), .fe_state(fe_state)
   );

   i2s_sample_frontend #(.data_width(16), .sample_width(24), .count_width(4)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable),
      .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
      .pipe_ready(sat_ready), .pipe_out_sample(16'h0000),
      .in_sample(sat_in_sample), .in_valid(sat_in_valid),
      .out_latched(sat_out_latched), .out_valid(sat_out_valid),
      .overrun_count(sat_count), .frame_error(sat_frame_error), .fe_state(sat_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks: one bclk period is 8 clk, inputs change while bclk is low
   task automatic bit_out(input logic lr, input logic d);
      i2s_lrclk = lr;
      i2s_sdata = d;
      #40 i2s_bclk = 1'b1;
      #40 i2s_bclk = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] w, input int nbits);
      bit_out(1'b1, 1'b0);
      bit_out(1'b1, 1'b0);
      bit_out(1'b0, 1'b1);
      for (int i = 0; i < nbits; i++) bit_out(1'b0, w[23-i]);
      bit_out(1'b1, 1'b0);
      bit_out(1'b1, 1'b0);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // pipeline model: drop ready one cycle after a handoff, return result 5 cycles later
   initial forever begin
      @(posedge clk); #1;
      if (model_on && in_valid) begin
         @(posedge clk); #1 pipe_ready = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         pipe_out_sample = model_resp;
         pipe_ready = 1'b1;
      end
   end

   // scoreboard monitor: log handoffs, flag any handoff before the previous result
   initial forever begin
      @(posedge clk); #1;
      if (!reset) busy = 1'b0;
      else begin
         if (in_valid) begin
            n_iv++;
            in_log.push_back(in_sample);
            if (busy) viol++;
            busy = 1'b1;
         end
         if (out_valid) begin
            n_ov++;
            busy = 1'b0;
         end
      end
   end

   initial begin
      bit found;
      @(posedge clk); #1;
      // reset state
      check_eq("rst_in_valid", in_valid, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_sample", in_sample, 0);
      check_eq("rst_out_latched", out_latched, 0);
      check_eq("rst_overrun", overrun_count, 0);
      check_eq("rst_frame_error", frame_error, 0);
      check_eq("rst_state", fe_state, FE_IDLE);
      wait_clks(3);
      reset = 1'b1;
      wait_clks(3);

      // basic handoff
      model_on = 1'b1; model_resp = 16'hBEEF; pipe_ready = 1'b1;
      send_word(24'h123456, 24);
      wait_clks(30);
      check_eq("basic_n_iv", n_iv, 1);
      check_eq("basic_in_sample", in_sample, 16'h1234);
      check_eq("basic_n_ov", n_ov, 1);
      check_eq("basic_out_latched", out_latched, 16'hBEEF);
      check_eq("basic_overrun", overrun_count, 0);

      // overrun: latest word wins
      model_on = 1'b0; pipe_ready = 1'b0;
      send_word(24'h111111, 24);
      send_word(24'h222222, 24);
      send_word(24'h333333, 24);
      wait_clks(5);
      check_eq("ovr_count", overrun_count, 2);
      check_eq("ovr_no_iv", n_iv, 1);
      model_resp = 16'h5A5A; model_on = 1'b1; pipe_ready = 1'b1;
      wait_clks(30);
      check_eq("ovr_n_iv", n_iv, 2);
      check_eq("ovr_in_sample", in_log[1], 16'h3333);
      check_eq("ovr_out_latched", out_latched, 16'h5A5A);

      // short word then a full word
      send_word(24'hABCDEF, 10);
      wait_clks(10);
      check_eq("short_frame_error", frame_error, 1);
      check_eq("short_no_iv", n_iv, 2);
      send_word(24'h7FFFFF, 24);
      wait_clks(30);
      check_eq("short_next_n_iv", n_iv, 3);
      check_eq("short_next_sample", in_log[2], 16'h7FFF);
      check_eq("short_sticky", frame_error, 1);

      // rx_done coincides with the issue cycle
      model_on = 1'b0; pipe_ready = 1'b0; model_resp = 16'hC0DE;
      send_word(24'h0A0A0A, 24);
      fork
         send_word(24'h0B0B0B, 24);
         begin
            found = 1'b0;
            for (int i = 0; i < 1000 && !found; i++) begin
               @(posedge clk); #1;
               if (dut.u_rx.rx_done) begin
                  found = 1'b1;
                  model_on = 1'b1;
                  pipe_ready = 1'b1;
               end
            end
            check_eq("simul_trigger", found, 1);
         end
      join
      wait_clks(40);
      check_eq("simul_n_iv", n_iv, 5);
      check_eq("simul_first", in_log[3], 16'h0A0A);
      check_eq("simul_second", in_log[4], 16'h0B0B);
      check_eq("simul_overrun", overrun_count, 2);
      check_eq("simul_order", viol, 0);
      check_eq("simul_n_ov", n_ov, 5);

      // enable low discards the word
      enable = 1'b0;
      send_word(24'h0ABCDE, 24);
      wait_clks(20);
      check_eq("enable_no_iv", n_iv, 5);
      enable = 1'b1;

      // reset while BUSY
      fork
         send_word(24'h0CCCCC, 24);
         begin
            found = 1'b0;
            for (int i = 0; i < 1000 && !found; i++) begin
               @(posedge clk); #2;
               if (n_iv == 6) found = 1'b1;
            end
            check_eq("busy_trigger", found, 1);
            repeat (3) @(posedge clk);
            #2 reset = 1'b0;
            #1;
            check_eq("busy_state_before", 32'(dut.fe_state == FE_IDLE), 1);
            check_eq("busyrst_in_valid", in_valid, 0);
            check_eq("busyrst_out_valid", out_valid, 0);
            check_eq("busyrst_in_sample", in_sample, 0);
            check_eq("busyrst_out_latched", out_latched, 0);
            check_eq("busyrst_overrun", overrun_count, 0);
            check_eq("busyrst_frame_error", frame_error, 0);
            wait_clks(3);
            reset = 1'b1;
         end
      join
      wait_clks(20);
      check_eq("busyrst_issued", in_log[5], 16'h0CCC);
      check_eq("busyrst_no_ov", n_ov, 5);
      check_eq("busyrst_state", fe_state, FE_IDLE);

      // saturation on the 4-bit counter instance
      model_on = 1'b0; pipe_ready = 1'b0;
      for (int k = 0; k < 21; k++) send_word(24'h100000 + 24'(k), 24);
      wait_clks(5);
      check_eq("sat_count", sat_count, 4'hF);
      check_eq("sat_main_count", overrun_count, 20);
      check_eq("sat_no_iv", n_iv, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
